// File: rtl/sine_wave_pkg.sv
// sine_wave_pkg
// Shared types and constants for the sine wave generator/monitor pair.
//   sample_t        : signed 16-bit two's-complement sample
//   monitor_state_t : monitor FSM states (SEARCH, TRACK)
//   DEFAULT_HYST    : default negative arming threshold magnitude
package sine_wave_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } monitor_state_t;

  localparam int DEFAULT_HYST = 16;

endpackage

// File: rtl/sine_wave_monitor_if.sv
// sine_wave_monitor_if
// Bundles the sample stream into the monitor and the measurement results out of it.
//   sample_in/sample_valid : sample stream, driven by the master
//   period                 : accepted-sample count of the last complete cycle
//   peak/trough            : signed max/min of the last complete cycle
//   amplitude              : unsigned peak minus trough (17 bits)
//   result_valid           : one-cycle pulse when the results update
//   locked/no_signal       : tracking status and sticky loss-of-signal flag
// The master modport belongs to the sample source; the slave modport belongs to the monitor.
interface sine_wave_monitor_if
  import sine_wave_pkg::*;
#(
  parameter int PERIOD_W = 24
) ();

  sample_t             sample_in;
  logic                sample_valid;
  logic [PERIOD_W-1:0] period;
  sample_t             peak;
  sample_t             trough;
  logic [16:0]         amplitude;
  logic                result_valid;
  logic                locked;
  logic                no_signal;

  modport master (
    output sample_in, sample_valid,
    input  period, peak, trough, amplitude, result_valid, locked, no_signal
  );

  modport slave (
    input  sample_in, sample_valid,
    output period, peak, trough, amplitude, result_valid, locked, no_signal
  );

endinterface

// File: rtl/zero_cross_detector.sv
// zero_cross_detector
// Hysteresis zero-crossing detector for the rising edge of a signed sample stream.
//   clk, rst : clock, asynchronous active-high reset
//   sample   : current sample
//   valid    : sample is accepted this cycle
//   disarm   : force the armed bit clear on this accepted sample
//   crossing : combinational strobe, high for the accepted sample that crosses zero
module zero_cross_detector
  import sine_wave_pkg::*;
#(
  parameter int HYST = DEFAULT_HYST
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t sample,
  input  logic    valid,
  input  logic    disarm,
  output logic    crossing
);

  localparam sample_t ARM_LEVEL = sample_t'(-HYST);

  logic armed;

  // A non-negative sample only counts as a crossing once the signal has dipped
  // clearly below zero, which rejects noise chattering around zero.
  assign crossing = valid && armed && !sample[15];

  // Armed bit: set by a sample below -HYST, cleared by the crossing that consumes it
  // or by an explicit disarm (loss of signal).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (valid) begin
      if (crossing || disarm) begin
        armed <= 1'b0;
      end else if (sample < ARM_LEVEL) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sine_wave_monitor.sv
// sine_wave_monitor
// Measures period, peak, trough and amplitude of a sampled sine wave, one result
// per complete cycle between rising zero crossings.
//   clk, rst : clock, asynchronous active-high reset
//   mon      : slave side of sine_wave_monitor_if (sample stream in, results out)
module sine_wave_monitor
  import sine_wave_pkg::*;
#(
  parameter int                  HYST     = DEFAULT_HYST,
  parameter int                  PERIOD_W = 24,
  parameter logic [PERIOD_W-1:0] TIMEOUT  = '1
) (
  input logic               clk,
  input logic               rst,
  sine_wave_monitor_if.slave mon
);

  monitor_state_t      state;
  logic [PERIOD_W-1:0] counter;
  sample_t             peak_acc;
  sample_t             trough_acc;
  logic                crossing;
  logic                timeout_hit;

  // Timeout only fires on a non-crossing sample, so a crossing arriving exactly
  // at the limit still completes the cycle.
  assign timeout_hit = mon.sample_valid && (state == TRACK) && !crossing &&
                       (counter == TIMEOUT);

  zero_cross_detector #(
    .HYST (HYST)
  ) u_detector (
    .clk      (clk),
    .rst      (rst),
    .sample   (mon.sample_in),
    .valid    (mon.sample_valid),
    .disarm   (timeout_hit),
    .crossing (crossing)
  );

  // Main FSM. The crossing sample opens the new cycle, so it seeds the counter
  // and accumulators instead of being folded into the cycle it just closed.
  // The first crossing after lock only starts measuring; results need a second one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= SEARCH;
      counter          <= '0;
      peak_acc         <= '0;
      trough_acc       <= '0;
      mon.period       <= '0;
      mon.peak         <= '0;
      mon.trough       <= '0;
      mon.amplitude    <= '0;
      mon.result_valid <= 1'b0;
      mon.locked       <= 1'b0;
      mon.no_signal    <= 1'b0;
    end else begin
      mon.result_valid <= 1'b0;
      if (crossing) begin
        state         <= TRACK;
        counter       <= PERIOD_W'(1);
        peak_acc      <= mon.sample_in;
        trough_acc    <= mon.sample_in;
        mon.no_signal <= 1'b0;
        if (state == TRACK) begin
          mon.period       <= counter;
          mon.peak         <= peak_acc;
          mon.trough       <= trough_acc;
          mon.amplitude    <= {peak_acc[15], peak_acc} - {trough_acc[15], trough_acc};
          mon.result_valid <= 1'b1;
          mon.locked       <= 1'b1;
        end
      end else if (timeout_hit) begin
        state         <= SEARCH;
        counter       <= '0;
        mon.locked    <= 1'b0;
        mon.no_signal <= 1'b1;
      end else if (mon.sample_valid && (state == TRACK)) begin
        counter <= counter + PERIOD_W'(1);
        if (mon.sample_in > peak_acc) begin
          peak_acc <= mon.sample_in;
        end
        if (mon.sample_in < trough_acc) begin
          trough_acc <= mon.sample_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_wave_monitor.sv
// tb_sine_wave_monitor
// Directed self-checking bench for sine_wave_monitor (HYST=16, PERIOD_W=24, TIMEOUT=32).
module tb_sine_wave_monitor;
  import sine_wave_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  sine_wave_monitor_if #(.PERIOD_W(24)) bus ();

  sine_wave_monitor #(
    .HYST     (16),
    .PERIOD_W (24),
    .TIMEOUT  (24'd32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one sample at the falling edge, then settle just after the rising edge.
  task automatic step(input sample_t s, input logic v);
    @(negedge clk);
    bus.sample_in    = s;
    bus.sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse used between scenarios.
  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Square-ish test waveform: four low samples then four high samples.
  function automatic sample_t pat(input int i, input sample_t lo, input sample_t hi);
    return ((i % 8) < 4) ? lo : hi;
  endfunction

  task automatic test_reset();
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.period !== 24'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_period got %0d want 0", bus.period);
    end
    vectors++;
    if ({bus.peak, bus.trough, bus.amplitude} !== 49'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_values got %h want 0", {bus.peak, bus.trough, bus.amplitude});
    end
    vectors++;
    if ({bus.result_valid, bus.locked, bus.no_signal} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 000", {bus.result_valid, bus.locked, bus.no_signal});
    end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    logic        exp_rv;
    logic [72:0] exp_res;
    exp_res = {24'd8, 16'sd100, -16'sd100, 17'd200};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(pat(i, -16'sd100, 16'sd100), 1'b1);
      exp_rv = (i >= 12) && ((i % 8) == 4);
      vectors++;
      if (bus.result_valid !== exp_rv) begin
        miscompares++;
        $display("[TB] FAIL cont_rv[%0d] got %b want %b", i, bus.result_valid, exp_rv);
      end
      if (exp_rv) begin
        vectors++;
        if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== exp_res ||
            bus.locked !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL cont_result[%0d] got %h/%b want %h/1", i,
                   {bus.period, bus.peak, bus.trough, bus.amplitude}, bus.locked, exp_res);
        end
      end
      if (i < 12) begin
        vectors++;
        if (bus.locked !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL cont_early_lock[%0d] got %b want 0", i, bus.locked);
        end
      end
    end
  endtask

  task automatic test_gapped();
    logic        exp_rv;
    logic [72:0] exp_res;
    exp_res = {24'd8, 16'sd100, -16'sd100, 17'd200};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(pat(i, -16'sd100, 16'sd100), 1'b1);
      exp_rv = (i >= 12) && ((i % 8) == 4);
      vectors++;
      if (bus.result_valid !== exp_rv) begin
        miscompares++;
        $display("[TB] FAIL gap_rv[%0d] got %b want %b", i, bus.result_valid, exp_rv);
      end
      if (exp_rv) begin
        vectors++;
        if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== exp_res) begin
          miscompares++;
          $display("[TB] FAIL gap_result[%0d] got %h want %h", i,
                   {bus.period, bus.peak, bus.trough, bus.amplitude}, exp_res);
        end
      end
      // Extreme value on an idle cycle must be ignored entirely.
      step(-16'sd32768, 1'b0);
      vectors++;
      if (bus.result_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL gap_idle_rv[%0d] got %b want 0", i, bus.result_valid);
      end
    end
  endtask

  task automatic test_no_arm();
    sample_t vals [8];
    vals = '{-16'sd5, -16'sd3, 16'sd0, 16'sd3, 16'sd5, 16'sd3, 16'sd0, -16'sd3};
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(vals[i % 8], 1'b1);
      vectors++;
      if (bus.result_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL noarm_rv[%0d] got %b want 0", i, bus.result_valid);
      end
    end
    vectors++;
    if ({bus.locked, bus.no_signal} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL noarm_flags got %b want 00", {bus.locked, bus.no_signal});
    end
  endtask

  task automatic test_hysteresis_boundary();
    sample_t     s;
    logic        exp_rv;
    logic [72:0] exp_res;
    exp_res = {24'd16, 16'sd100, -16'sd17, 17'd117};
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i < 16)      s = pat(i, -16'sd100, 16'sd100);
      else if (i < 24) s = pat(i, -16'sd16, 16'sd100);
      else             s = pat(i, -16'sd17, 16'sd100);
      step(s, 1'b1);
      exp_rv = (i == 12) || (i == 28);
      vectors++;
      if (bus.result_valid !== exp_rv) begin
        miscompares++;
        $display("[TB] FAIL hyst_rv[%0d] got %b want %b", i, bus.result_valid, exp_rv);
      end
    end
    vectors++;
    if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== exp_res) begin
      miscompares++;
      $display("[TB] FAIL hyst_result got %h want %h",
               {bus.period, bus.peak, bus.trough, bus.amplitude}, exp_res);
    end
  endtask

  task automatic test_timeout();
    logic [72:0] exp_res;
    exp_res = {24'd8, 16'sd100, -16'sd100, 17'd200};
    do_reset();
    for (int i = 0; i < 16; i++) step(pat(i, -16'sd100, 16'sd100), 1'b1);
    for (int i = 16; i <= 44; i++) begin
      step(16'sd50, 1'b1);
      vectors++;
      if (bus.no_signal !== (i == 44) || bus.locked !== (i != 44)) begin
        miscompares++;
        $display("[TB] FAIL timeout_flags[%0d] got ns=%b lk=%b want ns=%b lk=%b", i,
                 bus.no_signal, bus.locked, (i == 44), (i != 44));
      end
    end
    vectors++;
    if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== exp_res) begin
      miscompares++;
      $display("[TB] FAIL timeout_hold got %h want %h",
               {bus.period, bus.peak, bus.trough, bus.amplitude}, exp_res);
    end
    step(-16'sd100, 1'b1);
    vectors++;
    if (bus.no_signal !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_sticky got %b want 1", bus.no_signal);
    end
    step(16'sd100, 1'b1);
    vectors++;
    if ({bus.no_signal, bus.result_valid, bus.locked} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL timeout_recover got %b want 000",
               {bus.no_signal, bus.result_valid, bus.locked});
    end
  endtask

  task automatic test_full_scale();
    logic        exp_rv;
    logic [72:0] exp_res;
    exp_res = {24'd8, 16'sd32767, -16'sd32768, 17'd65535};
    do_reset();
    for (int i = 0; i < 24; i++) begin
      step(pat(i, -16'sd32768, 16'sd32767), 1'b1);
      exp_rv = (i == 12) || (i == 20);
      vectors++;
      if (bus.result_valid !== exp_rv) begin
        miscompares++;
        $display("[TB] FAIL full_rv[%0d] got %b want %b", i, bus.result_valid, exp_rv);
      end
      if (exp_rv) begin
        vectors++;
        if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== exp_res) begin
          miscompares++;
          $display("[TB] FAIL full_result[%0d] got %h want %h", i,
                   {bus.period, bus.peak, bus.trough, bus.amplitude}, exp_res);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic exp_rv;
    do_reset();
    for (int i = 0; i < 18; i++) step(pat(i, -16'sd100, 16'sd100), 1'b1);
    vectors++;
    if (bus.locked !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_prelock got %b want 1", bus.locked);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.period, bus.peak, bus.trough, bus.amplitude} !== 73'd0) begin
      miscompares++;
      $display("[TB] FAIL areset_values got %h want 0",
               {bus.period, bus.peak, bus.trough, bus.amplitude});
    end
    vectors++;
    if ({bus.result_valid, bus.locked, bus.no_signal} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL areset_flags got %b want 000",
               {bus.result_valid, bus.locked, bus.no_signal});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(pat(i, -16'sd100, 16'sd100), 1'b1);
      exp_rv = (i == 12);
      vectors++;
      if (bus.result_valid !== exp_rv || bus.locked !== (i >= 12)) begin
        miscompares++;
        $display("[TB] FAIL areset_restart[%0d] got rv=%b lk=%b want rv=%b lk=%b", i,
                 bus.result_valid, bus.locked, exp_rv, (i >= 12));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_continuous();
    test_gapped();
    test_no_arm();
    test_hysteresis_boundary();
    test_timeout();
    test_full_scale();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
